// File: rtl/conv_feeder_pkg.sv
// Shared state encoding and loop-nest constants for the convolution stream feeder.
package conv_feeder_pkg;

   typedef enum logic [2:0] {
      IDLE,
      KERN,
      INPT,
      COMP,
      DRAIN
   } feeder_state_t;

   localparam int unsigned KERNEL_BURSTS = 6;
   localparam int unsigned KERNEL_BEATS  = 12;
   localparam int unsigned INPUT_BURSTS  = 3;
   localparam int unsigned COLUMN_BEATS  = 4;
   localparam int unsigned CH_OUT_STEP   = 6;

endpackage

// File: rtl/feeder_fifo2.sv
// Two-entry FIFO holding SRAM returns until the device takes them; flush is synchronous.
module feeder_fifo2 #(
   parameter int unsigned DATA_WIDTH = 64
) (
   input  logic                  clk,
   input  logic                  flush,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  pop,
   output logic [DATA_WIDTH-1:0] head,
   output logic [1:0]            occ
);

   logic [DATA_WIDTH-1:0] mem [2];
   logic                  wr_ptr;
   logic                  rd_ptr;
   logic [1:0]            count;

   always_ff @(posedge clk) begin
      if (flush) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) wr_ptr <= ~wr_ptr;
         if (pop)  rd_ptr <= ~rd_ptr;
         count <= count + {1'b0, push} - {1'b0, pop};
      end
   end

   // Storage needs no reset: entries are only visible while count is non-zero.
   always_ff @(posedge clk) begin
      if (push && !flush) mem[wr_ptr] <= wr_data;
   end

   assign head = mem[rd_ptr];
   assign occ  = count;

endmodule

// File: rtl/conv_stream_feeder.sv
// Walks the kernel/input/compute loop nest, reads SRAM and streams beats to the device.
// Optional FEEDER_ZERO_PAD_EN substitutes zero words for right-edge padding columns.
module conv_stream_feeder
   import conv_feeder_pkg::*;
#(
   parameter int unsigned FEATURE_MAP_WIDTH  = 1024,
   parameter int unsigned FEATURE_MAP_HEIGHT = 1024,
   parameter int unsigned OUTPUT_NB_CHANNELS = 64,
   parameter int unsigned DATA_WIDTH         = 64,
   parameter int unsigned ADDR_WIDTH         = 20
) (
   input  logic                  clk,
   input  logic                  arst_n_in,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic                  k_rd_en,
   output logic                  f_rd_en,
   output logic [ADDR_WIDTH-1:0] k_rd_addr,
   output logic [ADDR_WIDTH-1:0] f_rd_addr,
   input  logic [DATA_WIDTH-1:0] rd_data,
   output logic                  con_valid,
   input  logic                  con_ready,
   output logic [DATA_WIDTH-1:0] con_data,
   input  logic                  driving_cons
);

   localparam int unsigned ROW_WORDS = FEATURE_MAP_WIDTH + 3;
   localparam int unsigned NG        = OUTPUT_NB_CHANNELS / CH_OUT_STEP;

   generate
      if (OUTPUT_NB_CHANNELS % CH_OUT_STEP != 0) begin : g_bad_channels
         $error("conv_stream_feeder: OUTPUT_NB_CHANNELS must be a multiple of 6");
      end
   endgenerate

   feeder_state_t state, state_nxt;
   logic [31:0] g, g_nxt, y, y_nxt, x, x_nxt;
   logic [3:0]  j, j_nxt;
   logic [2:0]  b, b_nxt;
   logic [1:0]  r, r_nxt, c, c_nxt;

   logic                  inflight, inflight_zero;
   logic [1:0]            occ;
   logic                  pop, issue, active, pad, drain_exit;
   logic [DATA_WIDTH-1:0] head, push_data;
   logic [31:0]           col32, k_addr32, f_addr32;

   assign con_valid  = (occ != 2'd0) && !driving_cons;
   assign con_data   = con_valid ? head : '0;
   assign pop        = con_valid && con_ready;
   assign active     = (state == KERN) || (state == INPT) || (state == COMP);
   // Credit: FIFO slots already claimed by stored or returning words, net of this cycle's pop.
   assign issue      = active && (({1'b0, occ} + {2'b0, inflight}) < (3'd2 + {2'b0, pop}));
   assign drain_exit = (state == DRAIN) && (occ == 2'd0) && !inflight;
   assign done       = drain_exit;
   assign busy       = (state != IDLE) && !drain_exit;

`ifdef FEEDER_ZERO_PAD_EN
   assign pad = (state == COMP) && ((x + 32'd3) > 32'(FEATURE_MAP_WIDTH + 1));
`else
   assign pad = 1'b0;
`endif

   assign k_rd_en   = issue && (state == KERN);
   assign f_rd_en   = issue && ((state == INPT) || (state == COMP)) && !pad;
   assign col32     = (state == COMP) ? (x + 32'd3) : {30'd0, r};
   assign k_addr32  = (g * CH_OUT_STEP + {29'd0, b}) * KERNEL_BEATS + {28'd0, j};
   assign f_addr32  = (y * ROW_WORDS + col32) * COLUMN_BEATS + {30'd0, c};
   assign k_rd_addr = k_addr32[ADDR_WIDTH-1:0];
   assign f_rd_addr = f_addr32[ADDR_WIDTH-1:0];

   assign push_data = inflight_zero ? '0 : rd_data;

   always_comb begin
      state_nxt = state;
      g_nxt = g;
      y_nxt = y;
      x_nxt = x;
      j_nxt = j;
      b_nxt = b;
      r_nxt = r;
      c_nxt = c;
      case (state)
         IDLE: begin
            g_nxt = '0; y_nxt = '0; x_nxt = '0;
            j_nxt = '0; b_nxt = '0; r_nxt = '0; c_nxt = '0;
            if (start) state_nxt = KERN;
         end
         KERN: if (issue) begin
            if (j == 4'(KERNEL_BEATS - 1)) begin
               j_nxt = '0;
               if (b == 3'(KERNEL_BURSTS - 1)) begin
                  b_nxt     = '0;
                  state_nxt = INPT;
               end else begin
                  b_nxt = b + 3'd1;
               end
            end else begin
               j_nxt = j + 4'd1;
            end
         end
         INPT: if (issue) begin
            if (c == 2'(COLUMN_BEATS - 1)) begin
               c_nxt = '0;
               if (r == 2'(INPUT_BURSTS - 1)) begin
                  r_nxt     = '0;
                  state_nxt = COMP;
               end else begin
                  r_nxt = r + 2'd1;
               end
            end else begin
               c_nxt = c + 2'd1;
            end
         end
         COMP: if (issue) begin
            if (c == 2'(COLUMN_BEATS - 1)) begin
               c_nxt = '0;
               if (x == 32'(FEATURE_MAP_WIDTH - 1)) begin
                  x_nxt = '0;
                  if (y != 32'(FEATURE_MAP_HEIGHT - 1)) begin
                     y_nxt     = y + 32'd1;
                     state_nxt = INPT;
                  end else if (g != 32'(NG - 1)) begin
                     g_nxt     = g + 32'd1;
                     y_nxt     = '0;
                     state_nxt = KERN;
                  end else begin
                     state_nxt = DRAIN;
                  end
               end else begin
                  x_nxt = x + 32'd1;
               end
            end else begin
               c_nxt = c + 2'd1;
            end
         end
         DRAIN: if (drain_exit) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!arst_n_in) begin
         state         <= IDLE;
         g             <= '0;
         y             <= '0;
         x             <= '0;
         j             <= '0;
         b             <= '0;
         r             <= '0;
         c             <= '0;
         inflight      <= 1'b0;
         inflight_zero <= 1'b0;
      end else begin
         state         <= state_nxt;
         g             <= g_nxt;
         y             <= y_nxt;
         x             <= x_nxt;
         j             <= j_nxt;
         b             <= b_nxt;
         r             <= r_nxt;
         c             <= c_nxt;
         inflight      <= issue;
         inflight_zero <= issue && pad;
      end
   end

   feeder_fifo2 #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_fifo (
      .clk     (clk),
      .flush   (!arst_n_in),
      .push    (inflight),
      .wr_data (push_data),
      .pop     (pop),
      .head    (head),
      .occ     (occ)
   );

endmodule

// File: tb/tb_conv_stream_feeder.sv
// Scoreboard bench for conv_stream_feeder: directed runs on two parameter sets.
module tb_conv_stream_feeder;

   localparam int unsigned DW = 64;
   localparam int unsigned AW = 20;
   localparam logic [63:0] FTAG = 64'h0000_0001_0000_0000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          arst_n, start_a, start_b, con_ready, driving_cons;
   logic          busy_a, done_a, k_en_a, f_en_a, con_valid_a;
   logic          busy_b, done_b, k_en_b, f_en_b, con_valid_b;
   logic [AW-1:0] k_addr_a, f_addr_a, k_addr_b, f_addr_b;
   logic [DW-1:0] rd_data_a, rd_data_b, con_data_a, con_data_b;

   conv_stream_feeder #(
      .FEATURE_MAP_WIDTH(2), .FEATURE_MAP_HEIGHT(2), .OUTPUT_NB_CHANNELS(6),
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW)
   ) dut_a (
      .clk(clk), .arst_n_in(arst_n), .start(start_a), .busy(busy_a), .done(done_a),
      .k_rd_en(k_en_a), .f_rd_en(f_en_a), .k_rd_addr(k_addr_a), .f_rd_addr(f_addr_a),
      .rd_data(rd_data_a), .con_valid(con_valid_a), .con_ready(con_ready),
      .con_data(con_data_a), .driving_cons(driving_cons)
   );

   conv_stream_feeder #(
      .FEATURE_MAP_WIDTH(1), .FEATURE_MAP_HEIGHT(1), .OUTPUT_NB_CHANNELS(12),
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW)
   ) dut_b (
      .clk(clk), .arst_n_in(arst_n), .start(start_b), .busy(busy_b), .done(done_b),
      .k_rd_en(k_en_b), .f_rd_en(f_en_b), .k_rd_addr(k_addr_b), .f_rd_addr(f_addr_b),
      .rd_data(rd_data_b), .con_valid(con_valid_b), .con_ready(con_ready),
      .con_data(con_data_b), .driving_cons(driving_cons)
   );

   // SRAM model: returns its address, feature words tagged so phases cannot be confused.
   always @(posedge clk) begin
      rd_data_a <= k_en_a ? 64'(k_addr_a) : f_en_a ? (FTAG | 64'(f_addr_a)) : 64'hBAD0_BAD0_BAD0_BAD0;
      rd_data_b <= k_en_b ? 64'(k_addr_b) : f_en_b ? (FTAG | 64'(f_addr_b)) : 64'hBAD0_BAD0_BAD0_BAD0;
   end

   logic [63:0] expq[$];
   bit          compq[$];
   int          n_assert = 0;
   int          n_fail   = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic void fill(input int unsigned ng, input int unsigned w, input int unsigned h);
      for (int unsigned g = 0; g < ng; g++) begin
         for (int unsigned b = 0; b < 6; b++)
            for (int unsigned j = 0; j < 12; j++) begin
               expq.push_back(64'((g * 6 + b) * 12 + j));
               compq.push_back(1'b0);
            end
         for (int unsigned y = 0; y < h; y++) begin
            for (int unsigned r = 0; r < 3; r++)
               for (int unsigned c = 0; c < 4; c++) begin
                  expq.push_back(FTAG | 64'((y * (w + 3) + r) * 4 + c));
                  compq.push_back(1'b0);
               end
            for (int unsigned x = 0; x < w; x++)
               for (int unsigned c = 0; c < 4; c++) begin
`ifdef FEEDER_ZERO_PAD_EN
                  if (x + 3 > w + 1) expq.push_back(64'd0);
                  else expq.push_back(FTAG | 64'((y * (w + 3) + x + 3) * 4 + c));
`else
                  expq.push_back(FTAG | 64'((y * (w + 3) + x + 3) * 4 + c));
`endif
                  compq.push_back(1'b1);
               end
         end
      end
   endfunction

   task automatic rst_chk(input string tag);
      chk({tag, "_busy"}, 64'(busy_a), 64'd0);
      chk({tag, "_done"}, 64'(done_a), 64'd0);
      chk({tag, "_k_en"}, 64'(k_en_a), 64'd0);
      chk({tag, "_f_en"}, 64'(f_en_a), 64'd0);
      chk({tag, "_valid"}, 64'(con_valid_a), 64'd0);
      chk({tag, "_k_addr"}, 64'(k_addr_a), 64'd0);
      chk({tag, "_f_addr"}, 64'(f_addr_a), 64'd0);
      chk({tag, "_data"}, con_data_a, 64'd0);
   endtask

   // mode 0: ready always high; 1: random ready; 2: bus stolen 2 cycles after every 4th compute beat
   task automatic run(input bit sel, input int mode, input int abort_at, input int exp_done);
      int          beat = 0;
      int          comp_seen = 0;
      int          drv_left = 0;
      bit          fin = 1'b0;
      bit          isc;
      logic        v, d, bz, ke, fe;
      logic [AW-1:0] ka;
      logic [63:0] data, exp;
      @(posedge clk); #1;
      if (sel) start_b = 1'b1; else start_a = 1'b1;
      con_ready    = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      driving_cons = 1'b0;
      for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
         @(negedge clk);
         v    = sel ? con_valid_b : con_valid_a;
         d    = sel ? done_b      : done_a;
         bz   = sel ? busy_b      : busy_a;
         ke   = sel ? k_en_b      : k_en_a;
         fe   = sel ? f_en_b      : f_en_a;
         ka   = sel ? k_addr_b    : k_addr_a;
         data = sel ? con_data_b  : con_data_a;
         if (cyc == 1) begin
            chk("busy_rise", 64'(bz), 64'd1);
            chk("first_k_en", 64'(ke), 64'd1);
            chk("first_k_addr", 64'(ka), 64'd0);
         end
         chk("rd_en_excl", 64'(ke && fe), 64'd0);
         if (driving_cons) begin
            chk("drv_valid", 64'(v), 64'd0);
            chk("drv_data", data, 64'd0);
         end
         if (v && con_ready) begin
            if (expq.size() == 0) begin
               chk("extra_beat", 64'(v), 64'd0);
            end else begin
               exp = expq.pop_front();
               isc = compq.pop_front();
               chk("beat_data", data, exp);
               if (mode == 2 && isc) begin
                  comp_seen++;
                  if (comp_seen % 4 == 0) drv_left = 2;
               end
            end
            if (mode == 0) chk("beat_cycle", 64'(cyc), 64'(3 + beat));
            beat++;
            if (beat == abort_at) fin = 1'b1;
         end
         if (d) begin
            chk("busy_at_done", 64'(bz), 64'd0);
            chk("beats_left", 64'(expq.size()), 64'd0);
            if (exp_done > 0) chk("done_cycle", 64'(cyc), 64'(exp_done));
            fin = 1'b1;
         end
         if (!fin) begin
            @(posedge clk); #1;
            start_a      = 1'b0;
            start_b      = 1'b0;
            con_ready    = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            driving_cons = (drv_left > 0);
            if (drv_left > 0) drv_left--;
         end
      end
      chk("run_complete", 64'(fin), 64'd1);
      start_a = 1'b0;
      start_b = 1'b0;
   endtask

   initial begin
      arst_n       = 1'b0;
      start_a      = 1'b0;
      start_b      = 1'b0;
      con_ready    = 1'b0;
      driving_cons = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_chk("reset");
      @(posedge clk); #1;
      arst_n = 1'b1;

      fill(1, 2, 2);
      run(1'b0, 0, 0, 115);

      fill(1, 2, 2);
      run(1'b0, 1, 0, 0);

      fill(1, 2, 2);
      run(1'b0, 2, 0, 0);

      fill(1, 2, 2);
      run(1'b0, 0, 41, 0);
      @(posedge clk); #1;
      arst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_chk("midrun_reset");
      @(posedge clk); #1;
      arst_n = 1'b1;
      expq.delete();
      compq.delete();
      fill(1, 2, 2);
      run(1'b0, 0, 0, 115);

      fill(2, 1, 1);
      run(1'b1, 0, 0, 179);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/conv_stream_feeder.md
# conv_stream_feeder

Host-side transmitter for the convolution accelerator's consumer stream. It walks the same loop nest the device controller consumes: per 6-output-channel group, 6 kernel bursts; per row, 3 input-column bursts; per x, one input-column burst. For each beat it fetches a word from kernel or feature-map SRAM and presents it on `con_data` with a `con_valid`/`con_ready` handshake. It releases the bus whenever the device asserts `driving_cons`.

## Interface
- FEATURE_MAP_WIDTH, 1024: output columns per row (x range).
- FEATURE_MAP_HEIGHT, 1024: output rows (y range).
- OUTPUT_NB_CHANNELS, 64: output channels. Must be a multiple of 6; elaboration-time `$error` otherwise.
- DATA_WIDTH, 64: beat/word width.
- ADDR_WIDTH, 20: SRAM word-address width.
- clk  in  1  sole clock.
- arst_n_in  in  1  reset, synchronous, active-low; sampled on the rising edge of `clk`.
- start  in  1  one-cycle launch request.
- busy  out  1  high from the cycle after `start` is accepted until `done`.
- done  out  1  one-cycle pulse after the last beat handshake.
- k_rd_en / f_rd_en  out  1  kernel / feature SRAM read strobes; never both high.
- k_rd_addr / f_rd_addr  out  ADDR_WIDTH  read addresses.
- rd_data  in  DATA_WIDTH  read return, valid exactly 1 cycle after a strobe.
- con_valid  out  1  beat available.
- con_ready  in  1  device accepts.
- con_data  out  DATA_WIDTH  beat payload.
- driving_cons  in  1  device owns the shared bus this cycle.

## Operation
- Beat order and addresses (G = group, b = burst, j/c = beat):
  - Kernel phase: for G in 0..OUTPUT_NB_CHANNELS/6-1, b in 0..5, j in 0..11:
    - `k_rd_addr = (G*6+b)*12 + j`.
  - Input phase: for each y, r in 0..2 (window column), c in 0..3:
    - `f_rd_addr = (y*ROW_WORDS + r)*4 + c`, where ROW_WORDS = FEATURE_MAP_WIDTH+3.
  - Compute phase: for each x, c in 0..3:
    - `f_rd_addr = (y*ROW_WORDS + x+3)*4 + c`.
- Phase sequence after the compute phase for x = W-1:
  - if y < H-1: input phase, y+1.
  - else if G < last: kernel phase, G+1, y = 0.
  - else: DRAIN.
- FSM states: IDLE, KERN, INPT, COMP, DRAIN.
  - IDLE → KERN when `start`.
  - DRAIN → IDLE when the FIFO is empty and no read is in flight; `done` pulses on that transition.
  - Counters G, b, j, y, r, c, x advance on read *issue*, not on handshake.
- Read issue rule (credit): issue when `occ + inflight - pop < 2`.
  - occ = FIFO occupancy (0..2); inflight = read issued last cycle (0/1); pop = `con_valid && con_ready`.
  - This sustains 1 beat/cycle.
- Returned `rd_data` is always written into a 2-entry FIFO.
  - `con_valid = (occ != 0) && !driving_cons`; `con_data` = FIFO head.
  - While `driving_cons` is high: no pop, FIFO retains data, and `con_data` is driven to 0.
- All address arithmetic is 32-bit internally, truncated to ADDR_WIDTH.
- `start` while `busy` is ignored.
- Reset, including mid-run: at the next edge, state IDLE, all counters 0, FIFO flushed, in-flight return discarded.
- Outputs after reset:
  - `busy`, `done`, `k_rd_en`, `f_rd_en`, `con_valid` = 0.
  - addresses = 0; `con_data` = 0.

## Timing
- `start` high in cycle 0 → `k_rd_en` with address 0 in cycle 1 → `con_valid` in cycle 3.
- `busy` rises in cycle 1.
- With `con_ready` held high and `driving_cons` low: one beat per cycle, no bubbles, including across phase boundaries.
- A `con_ready` drop stalls issue within one cycle. The FIFO absorbs at most the one read in flight, so there is no overflow.
- Total beats per run = NG*(72 + H*(12 + 4W)), where NG = OUTPUT_NB_CHANNELS/6.
- `done` rises 1 cycle after the final handshake, in the same cycle `busy` falls.

## Configuration
- `FEEDER_ZERO_PAD_EN` defined:
  - Compute-phase beats with x+3 > FEATURE_MAP_WIDTH+1 issue no SRAM read.
  - Instead, a zero word is written to the FIFO in the cycle a read would have returned.
  - This keeps the same latency and credit accounting; the SRAM then needs only FEATURE_MAP_WIDTH+2 columns per row.
- Not defined: every beat reads SRAM; the memory must hold padding columns.

## Structure
- `conv_feeder_pkg` holds:
  - the state enum;
  - constants `KERNEL_BURSTS=6`, `KERNEL_BEATS=12`, `INPUT_BURSTS=3`, `COLUMN_BEATS=4`, `CH_OUT_STEP=6`.
- One sub-module, `feeder_fifo2`: a 2-entry FIFO with occupancy output and synchronous flush.

## Test plan
Parameters for the first three scenarios: W=2, H=2, OUTPUT_NB_CHANNELS=6, SRAM returns its address as data.
- Basic run: `start` with `con_ready` always high → 112 beats on consecutive cycles from cycle 3.
  - Beats 0–71 carry kernel addresses 0..71; beat 72 carries f_addr 0; `done` in cycle 115.
- Random `con_ready` (50%) → identical beat sequence, no drops or duplicates, FIFO occupancy never exceeds 2.
- `driving_cons` high for 2 cycles after every 4th compute beat → `con_valid` low in those cycles; sequence and total unchanged.
- Reset asserted at beat 40, then `start` again → the next beat carries k_addr 0; no stale FIFO data appears.
- OUTPUT_NB_CHANNELS=12, W=1, H=1 → 2 groups of 88 beats.
  - The second group's first beat has k_addr 72.
  - Its input phase restarts at f_addr 0.
- With `FEEDER_ZERO_PAD_EN`, W=2 → compute beats for x=1 (column 4) carry data 0 and raise no `f_rd_en`; x=0 (column 3) still reads SRAM.
